muldiv_seq: RTL
===============

Name: muldiv_seq

Overview:
Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU. It owns the HI/LO register pair and sits beside the ALU in the EX stage. The CPU stalls while busy is high. Operations run as iterative shift-add multiply and restoring divide, one iteration per clock, using a private 33-bit add/subtract slice. The main ALU is never borrowed.

Parameters:
WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
start  in  1  launch request; sampled only in IDLE
op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
dataA  in  WIDTH  multiplicand / dividend (rs)
dataB  in  WIDTH  multiplier / divisor (rt)
hi_we  in  1  MTHI write strobe
lo_we  in  1  MTLO write strobe
wdata  in  WIDTH  MTHI/MTLO data
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse; hi/lo valid this cycle
div_by_zero  out  1  qualifies done; high only for a divide with dataB==0
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0. Reset wins over every other input, including mid-operation; a partial result is discarded.
- States: IDLE, PREP, RUN, FIX, DONE.
- IDLE -> PREP: on start=1.
  - Latch op.
  - For signed ops, latch |dataA| and |dataB| plus sign flags; unsigned ops latch the raw values.
  - Iteration counter loads WIDTH-1.
- PREP -> DONE: divide with divisor==0.
  - hi <= dividend as given, lo <= all ones, div_by_zero=1.
  - Latency: start edge t, done=1 in cycle t+2.
- PREP -> RUN: all other cases. Accumulator clears; the working register loads the operand.
- RUN, multiply: when acc_lo[0]=1, {c,upper} = upper + mcand (33-bit); otherwise no add. Then shift {c,upper,acc_lo} right by 1.
- RUN, divide: shift {rem,quot} left by 1, then trial = rem - divisor (33-bit).
  - No borrow: rem <= trial, quot[0] <= 1.
  - Borrow: rem unchanged, quot[0] <= 0.
- RUN timing: counter decrements each cycle; RUN -> FIX when counter==0, giving exactly WIDTH RUN cycles.
- FIX, signed fix-up:
  - MULT: negate the 2*WIDTH product when the signs differ.
  - DIV: negate the quotient when the signs differ; the remainder takes the dividend's sign.
  - hi <= product[2W-1:W] or remainder; lo <= product[W-1:0] or quotient.
- FIX -> DONE: unconditional.
- DONE -> IDLE: unconditional. done=1 for exactly this cycle.
- Normal latency: start sampled at edge t; done=1 in cycle t+WIDTH+3 (35 for WIDTH=32). Earliest next accepted start is the cycle after done.
- start while busy=1 is ignored; it is neither queued nor an error.
- hi_we/lo_we:
  - Honoured only when busy=0; ignored while busy.
  - hi_we and lo_we together write both registers.
  - start and hi_we/lo_we in the same IDLE cycle: the write takes effect, and the operation later overwrites HI/LO at FIX.
- Overflow case: DIV 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0, with no flag.
- hi/lo hold their values except at FIX, the divide-by-zero PREP->DONE transition, MTHI/MTLO writes, and reset.
- All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings: OP_MULTU, OP_MULT, OP_DIVU, OP_DIV
  - state encoding: S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE
  - default WIDTH
- Sub-module muldiv_addsub: WIDTH+1-bit adder/subtractor.
  - Inputs: a, b, sub.
  - Outputs: sum, carry/borrow.
  - Shared by the multiply and divide iterations.
- The FSM, counter and shift registers stay in muldiv_seq.

Test Plan:
1. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy high from t+1; done at t+35; hi=0xFFFFFFFE, lo=0x00000001; div_by_zero=0.
2. MULT 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then MULT 0 x 0x12345678 -> hi=lo=0.
3. DIVU 100/7 -> lo=14, hi=2. DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7 / 0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
4. DIVU 5/0 -> done at t+2 with div_by_zero=1, hi=5, lo=0xFFFFFFFF; next DIVU 9/3 -> div_by_zero=0, lo=3, hi=0.
5. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. Pulse start again at t+10 -> ignored, exactly one done observed.
6. MTHI 0xA5A5A5A5 in IDLE -> hi updates next cycle. MTLO during busy -> lo unchanged. rst at t+12 of a MULTU -> next cycle busy=0, hi=lo=0, no done pulse.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

endpackage

// File: rtl/muldiv_addsub.sv
// Private (WIDTH+1)-bit add/subtract slice for the shift-add and restoring
// divide iterations. cb is the carry-out when adding, the borrow when subtracting.
module muldiv_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    input  logic           sub,
    output logic [WIDTH:0] sum,
    output logic           cb
);

    logic [WIDTH+1:0] full;

    assign full = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{(WIDTH+1){1'b0}}, sub};
    assign sum  = full[WIDTH:0];
    assign cb   = sub ? ~full[WIDTH+1] : full[WIDTH+1];

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair.
//
//   state  | meaning
//   IDLE   | waiting for start; MTHI/MTLO honoured here
//   PREP   | operands latched; divide-by-zero short-cut or clear accumulator
//   RUN    | one shift-add / restoring-divide step per clock, WIDTH steps
//   FIX    | signed correction, result written to HI/LO
//   DONE   | done pulse, result visible on hi/lo
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    state_t state, state_nxt;

    logic [1:0]         op_r;
    logic               neg_a, neg_b, dbz_r;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   upper, acc_lo;     // {rem,quot} when dividing
    logic [CW-1:0]      cnt;

    logic               is_div, flip;
    logic [WIDTH-1:0]   abs_a, abs_b, dividend_raw;
    logic [WIDTH-1:0]   quot_fix, rem_fix;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH:0]     as_a, as_b, as_sum;
    logic               as_cb;

    assign is_div = op_r[1];
    assign flip   = neg_a ^ neg_b;

    assign abs_a  = (op[0] && dataA[WIDTH-1]) ? -dataA : dataA;
    assign abs_b  = (op[0] && dataB[WIDTH-1]) ? -dataB : dataB;

    // The signed dividend is rebuilt from its magnitude for the divide-by-zero result.
    assign dividend_raw = neg_a ? -a_mag : a_mag;

    assign prod     = {upper, acc_lo};
    assign prod_fix = flip ? -prod : prod;
    assign quot_fix = flip ? -acc_lo : acc_lo;
    assign rem_fix  = neg_a ? -upper : upper;

    // Adder operands: multiplicand-or-zero when multiplying, shifted remainder minus divisor when dividing.
    always_comb begin
        if (is_div) begin
            as_a = {upper, acc_lo[WIDTH-1]};
            as_b = {1'b0, b_mag};
        end else begin
            as_a = {1'b0, upper};
            as_b = {1'b0, (acc_lo[0] ? a_mag : {WIDTH{1'b0}})};
        end
    end

    muldiv_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a   (as_a),
        .b   (as_b),
        .sub (is_div),
        .sum (as_sum),
        .cb  (as_cb)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_PREP;
            end
            S_PREP:  state_nxt = (is_div && (b_mag == '0)) ? S_DONE : S_RUN;
            S_RUN:   if (cnt == '0) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign div_by_zero = done & dbz_r;

    // Operand latch, iteration datapath, down-counter and HI/LO registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r   <= OP_MULTU;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            dbz_r  <= 1'b0;
            a_mag  <= '0;
            b_mag  <= '0;
            upper  <= '0;
            acc_lo <= '0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        op_r  <= op;
                        neg_a <= op[0] & dataA[WIDTH-1];
                        neg_b <= op[0] & dataB[WIDTH-1];
                        a_mag <= abs_a;
                        b_mag <= abs_b;
                        cnt   <= CW'(WIDTH - 1);
                    end
                end
                S_PREP: begin
                    if (is_div && (b_mag == '0)) begin
                        hi    <= dividend_raw;
                        lo    <= '1;
                        dbz_r <= 1'b1;
                    end else begin
                        upper  <= '0;
                        acc_lo <= is_div ? a_mag : b_mag;
                        dbz_r  <= 1'b0;
                    end
                end
                S_RUN: begin
                    cnt <= cnt - CW'(1);
                    if (is_div) begin
                        if (as_cb) begin
                            upper  <= {upper[WIDTH-2:0], acc_lo[WIDTH-1]};
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                        end else begin
                            upper  <= as_sum[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                        end
                    end else begin
                        upper  <= as_sum[WIDTH:1];
                        acc_lo <= {as_sum[0], acc_lo[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
